// File: rtl/i2s_tx_master_sequencer_pkg.sv
// Shared I2S transmit types: state encoding, legal word/frame sizes and slot helpers.
package i2s_tx_master_sequencer_pkg;

   localparam int unsigned DATA_WIDTH   = 32;
   localparam int unsigned MAXIMUM_SIZE = 64;
   localparam int unsigned SLOT_WIDTH   = 6;

   typedef enum logic [2:0] {
      RESET_ACTIVATED   = 3'd0,
      RESET_DEACTIVATED = 3'd1,
      IDLE              = 3'd2,
      LEFT_CHANNEL      = 3'd3,
      RIGHT_CHANNEL     = 3'd4
   } i2sStateEnum;

   typedef enum logic [5:0] {
      BITS_8  = 6'd8,
      BITS_16 = 6'd16,
      BITS_24 = 6'd24,
      BITS_32 = 6'd32
   } numOfBitsTransferEnum;

   typedef enum logic [6:0] {
      WS_16 = 7'd16,
      WS_32 = 7'd32,
      WS_48 = 7'd48,
      WS_64 = 7'd64
   } wordSelectPeriodEnum;

   typedef enum logic {
      MONO   = 1'b0,
      STEREO = 1'b1
   } numOfChannelsEnum;

   // Index of the last slot of a channel half (period/2 - 1, never below 0).
   function automatic logic [SLOT_WIDTH-1:0] last_slot(input logic [6:0] ws_period);
      logic [SLOT_WIDTH-1:0] half;
      half = ws_period[6:1];
      return (half == '0) ? '0 : half - SLOT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/i2s_sclk_divider.sv
// sclk generator: toggles every clk_div clks while run is high (0 acts as 1); fall_c flags the clk whose edge drops sclk.
module i2s_sclk_divider #(
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] clk_div,
   output logic                 sclk,
   output logic                 fall_c
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] div_m1;
   logic                 tick_c;

   assign div_m1 = (clk_div == '0) ? '0 : clk_div - DIV_WIDTH'(1);
   assign tick_c = run && (cnt == div_m1);
   assign fall_c = tick_c && sclk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (!run) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (tick_c) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/i2s_tx_master_sequencer.sv
// I2S master transmitter: fetches stereo frames and serialises them MSB-first on sd with ws/sclk.
// Define I2S_TX_STATUS_CNT_EN to add the saturating frame_cnt/underrun_cnt status ports.
module i2s_tx_master_sequencer
   import i2s_tx_master_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [DIV_WIDTH-1:0]  cfg_clk_div,
   input  logic [5:0]            cfg_bits,
   input  logic [6:0]            cfg_ws_period,
   input  logic                  cfg_stereo,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   input  logic [DATA_WIDTH-1:0] frame_left,
   input  logic [DATA_WIDTH-1:0] frame_right,
   output logic                  sclk,
   output logic                  ws,
   output logic                  sd,
   output logic [2:0]            state,
   output logic                  busy,
   output logic                  underrun
`ifdef I2S_TX_STATUS_CNT_EN
   ,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           underrun_cnt
`endif
);

   i2sStateEnum           cur_state, nxt_state;
   numOfChannelsEnum      stereo_q;
   logic [SLOT_WIDTH-1:0] slot, last_q, next_slot;
   logic [5:0]            bits_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [DATA_WIDTH-1:0] shreg, right_q;
   logic                  run, fall_c, last_c, next_right;
   logic                  start_c, fetch_c, stop_c, frame_end_c;

   // Left-justify a right-aligned word so the MSB of a bits-wide sample sits at the top.
   function automatic logic [DATA_WIDTH-1:0] align_word(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [5:0]            bits);
      if (32'(bits) >= DATA_WIDTH) return word;
      return word << (DATA_WIDTH - 32'(bits));
   endfunction

   assign run    = (cur_state == LEFT_CHANNEL) || (cur_state == RIGHT_CHANNEL);
   assign last_c = (slot == last_q);
   assign sd     = shreg[DATA_WIDTH-1];
   assign state  = cur_state;

   i2s_sclk_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .clk_div (div_q),
      .sclk    (sclk),
      .fall_c  (fall_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_state <= RESET_ACTIVATED;
         busy      <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         busy      <= (nxt_state == LEFT_CHANNEL) || (nxt_state == RIGHT_CHANNEL);
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         RESET_ACTIVATED:   nxt_state = RESET_DEACTIVATED;
         RESET_DEACTIVATED: nxt_state = IDLE;
         IDLE:              if (start_c) nxt_state = LEFT_CHANNEL;
         LEFT_CHANNEL:      if (fall_c && last_c) nxt_state = RIGHT_CHANNEL;
         RIGHT_CHANNEL: begin
            if (fetch_c)     nxt_state = LEFT_CHANNEL;
            else if (stop_c) nxt_state = IDLE;
         end
         default:           nxt_state = IDLE;
      endcase
   end

   // Handshake and frame-boundary decode; the fetch window is the fall event closing RIGHT.
   always_comb begin
      frame_ready = 1'b0;
      start_c     = 1'b0;
      fetch_c     = 1'b0;
      stop_c      = 1'b0;
      frame_end_c = 1'b0;
      case (cur_state)
         IDLE: begin
            start_c     = enable && frame_valid;
            frame_ready = start_c;
         end
         RIGHT_CHANNEL: begin
            frame_end_c = fall_c && last_c;
            fetch_c     = frame_end_c && enable;
            stop_c      = frame_end_c && !enable;
            frame_ready = fetch_c;
         end
         default: ;
      endcase
   end

   always_comb begin
      next_slot  = last_c ? '0 : slot + SLOT_WIDTH'(1);
      next_right = last_c ? (cur_state == LEFT_CHANNEL) : (cur_state == RIGHT_CHANNEL);
   end

   // ws flips one slot early so it leads the data by one sclk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q    <= '0;
         bits_q   <= '0;
         last_q   <= '0;
         stereo_q <= MONO;
         slot     <= '0;
         shreg    <= '0;
         right_q  <= '0;
         ws       <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (start_c) begin
            div_q    <= cfg_clk_div;
            bits_q   <= cfg_bits;
            last_q   <= last_slot(cfg_ws_period);
            stereo_q <= numOfChannelsEnum'(cfg_stereo);
            shreg    <= align_word(frame_left, cfg_bits);
            right_q  <= align_word(cfg_stereo ? frame_right : frame_left, cfg_bits);
            slot     <= '0;
            ws       <= (last_slot(cfg_ws_period) == '0);
         end else if (fall_c) begin
            slot <= next_slot;
            ws   <= (next_slot == last_q) ? !next_right : next_right;
            if (!last_c) begin
               shreg <= shreg << 1;
            end else if (cur_state == LEFT_CHANNEL) begin
               shreg <= right_q;
            end else if (fetch_c) begin
               if (frame_valid) begin
                  shreg   <= align_word(frame_left, bits_q);
                  right_q <= align_word((stereo_q == STEREO) ? frame_right : frame_left, bits_q);
               end else begin
                  shreg    <= '0;
                  right_q  <= '0;
                  underrun <= 1'b1;
               end
            end else begin
               shreg <= '0;
               ws    <= 1'b0;
            end
         end
      end
   end

`ifdef I2S_TX_STATUS_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt    <= '0;
         underrun_cnt <= '0;
      end else begin
         if (frame_end_c && (frame_cnt != 16'hFFFF))
            frame_cnt <= frame_cnt + 16'd1;
         if (fetch_c && !frame_valid && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

endmodule
